// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits,
// odd parity and stop, then the device ACK, over open-drain clock/data pads.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    // INHIBIT exits one cycle early so that, with the RELEASE cycle, the clock
    // is held low for exactly INHIBIT_CYCLES cycles.
    localparam logic [IW-1:0] INH_LAST = IW'((INHIBIT_CYCLES > 1) ? INHIBIT_CYCLES - 2 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RELEASE,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t state, state_n;

    logic          clk_meta, clk_sync, clk_prev;
    logic          data_meta, data_sync;
    logic          clk_fall;

    logic [IW-1:0] inh_cnt, inh_cnt_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          parity, parity_n;
    logic          clk_oe_q, clk_oe_n;
    logic          data_oe_q, data_oe_n;
    logic          done_q, done_n;
    logic          err_q, err_n;

    // Synchronizers reset to the idle-high bus level so no spurious fall appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            parity    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            inh_cnt   <= inh_cnt_n;
            to_cnt    <= to_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            parity    <= parity_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        inh_cnt_n = inh_cnt;
        to_cnt_n  = to_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        parity_n  = parity;
        clk_oe_n  = clk_oe_q;
        data_oe_n = data_oe_q;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_valid) begin
                    shreg_n   = tx_data;
                    parity_n  = ~^tx_data;
                    clk_oe_n  = 1'b1;
                    inh_cnt_n = '0;
                    state_n   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (inh_cnt >= INH_LAST) begin
                    data_oe_n = 1'b1;
                    state_n   = S_RELEASE;
                end else begin
                    inh_cnt_n = inh_cnt + 1'b1;
                end
            end

            S_RELEASE: begin
                clk_oe_n  = 1'b0;
                bit_cnt_n = '0;
                to_cnt_n  = '0;
                state_n   = S_SEND;
            end

            S_SEND, S_ACK, S_WAIT_IDLE: begin
                // The timeout overrides any bit activity in the same cycle.
                if (to_cnt == TO_LAST) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    err_n     = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    to_cnt_n = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
                    case (state)
                        S_SEND: begin
                            if (clk_fall) begin
                                bit_cnt_n = bit_cnt + 1'b1;
                                if (bit_cnt < 4'd8) begin
                                    data_oe_n = ~shreg[bit_cnt[2:0]];
                                end else if (bit_cnt == 4'd8) begin
                                    data_oe_n = ~parity;
                                end else begin
                                    data_oe_n = 1'b0;
                                    state_n   = S_ACK;
                                end
                            end
                        end
                        S_ACK: begin
                            if (clk_fall) begin
                                if (!data_sync) begin
                                    state_n = S_WAIT_IDLE;
                                end else begin
                                    err_n   = 1'b1;
                                    state_n = S_IDLE;
                                end
                            end
                        end
                        default: begin
                            if (clk_sync && data_sync) begin
                                done_n  = 1'b1;
                                state_n = S_IDLE;
                            end
                        end
                    endcase
                end
            end

            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

    assign tx_ready    = (state == S_IDLE);
    assign tx_done     = done_q;
    assign tx_error    = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
